// File: rtl/ifu.sv
// Instruction fetch unit: walks one AXI-lite style read per instruction through
// REQ -> RESP -> OUT and waits for the execute side to supply the next PC.
module ifu #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction memory read-address channel
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  // instruction memory read-data channel
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // decode-side hand-over
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  // next PC from execute
  input  logic                  npc_valid,
  input  logic [ADDR_WIDTH-1:0] npc,
  output logic [31:0]           fetch_cnt,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once valid is raised, it and its payload hold until that edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RESP   = 3'd2,
    S_OUT    = 3'd3,
    S_WAITPC = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_misaligned;
  logic                  npc_aligned;
  logic                  bus_err;

  assign araddr        = pc;
  assign dbg_state     = state;
  assign pc_misaligned = |pc[1:0];
  assign npc_aligned   = ~|npc[1:0];
  assign bus_err       = |rresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'h0000_0000;
      inst_pc    <= RESET_PC;
      inst_fault <= 1'b0;
      fetch_cnt  <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_REQ;
          arvalid <= ~pc_misaligned;
        end

        // A misaligned PC never reaches the bus; it becomes a faulting slot.
        S_REQ: begin
          if (pc_misaligned) begin
            arvalid    <= 1'b0;
            inst       <= 32'h0000_0000;
            inst_fault <= 1'b1;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_OUT;
          end else if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RESP;
          end
        end

        S_RESP: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst       <= bus_err ? 32'h0000_0000 : rdata;
            inst_fault <= bus_err;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_OUT;
          end
        end

        // npc_valid only matters once the current instruction is consumed.
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
            if (npc_valid) begin
              pc      <= npc;
              arvalid <= npc_aligned;
              state   <= S_REQ;
            end else begin
              state <= S_WAITPC;
            end
          end
        end

        S_WAITPC: begin
          if (npc_valid) begin
            pc      <= npc;
            arvalid <= npc_aligned;
            state   <= S_REQ;
          end
        end

        default: begin
          state      <= S_IDLE;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_inst_stable: assert property (@(posedge clk) disable iff (rst)
    (inst_valid && !inst_ready) |=>
      (inst_valid && $stable(inst) && $stable(inst_pc) && $stable(inst_fault)));

  a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(arvalid && rready));

endmodule
